// File: rtl/uart_serializer_if.sv
// Producer-to-serializer handshake plus the serial line outputs.
// Signal suffixes are from the serializer's point of view.
interface uart_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_v_i;
    logic [DATA_BITS-1:0] tx_i;
    logic                 tx_ready_and_o;
    logic                 tx_o;
    logic                 tx_v_o;
    logic                 tx_done_o;

    modport slave (
        input  tx_v_i, tx_i,
        output tx_ready_and_o, tx_o, tx_v_o, tx_done_o
    );

    modport master (
        output tx_v_i, tx_i,
        input  tx_ready_and_o, tx_o, tx_v_o, tx_done_o
    );
endinterface

// File: rtl/uart_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, 1-2 stop bits.
// One word per valid/ready handshake; all line-side outputs are registered.
module uart_serializer #(
    parameter int clk_per_bit_p = 30,
    parameter int data_bits_p   = 8,
    parameter int parity_bits_p = 0,
    parameter int parity_odd_p  = 0,
    parameter int stop_bits_p   = 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    uart_serializer_if.slave tx_io
);

    if (data_bits_p < 5 || data_bits_p > 9) begin : g_bad_data_bits
        $fatal(1, "uart_serializer: data_bits_p must be 5..9");
    end
    if (stop_bits_p < 1 || stop_bits_p > 2) begin : g_bad_stop_bits
        $fatal(1, "uart_serializer: stop_bits_p must be 1 or 2");
    end
    if (clk_per_bit_p < 2) begin : g_bad_clk_per_bit
        $fatal(1, "uart_serializer: clk_per_bit_p must be >= 2");
    end

    localparam int CntW = $clog2(clk_per_bit_p);
    localparam int IdxW = $clog2(data_bits_p + 1);

    localparam logic [CntW-1:0] CntLast  = CntW'(clk_per_bit_p - 1);
    localparam logic [CntW-1:0] CntPen   = CntW'(clk_per_bit_p - 2);
    localparam logic [IdxW-1:0] DataLast = IdxW'(data_bits_p - 1);
    localparam logic [IdxW-1:0] StopLast = IdxW'(stop_bits_p - 1);
    localparam logic            ParOdd   = (parity_odd_p != 0);
    localparam bit              HasPar   = (parity_bits_p != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic [IdxW-1:0]        idx_q;     // data bit index in DATA, stop bit index in STOP
    logic [data_bits_p-1:0] shift_q;
    logic                   par_q;
    logic                   tx_q;
    logic                   v_q;
    logic                   done_q;
    logic                   accept;

    assign tx_io.tx_ready_and_o = reset_n_i & (state_q == S_IDLE);
    assign accept               = tx_io.tx_v_i & tx_io.tx_ready_and_o;

    assign tx_io.tx_o      = tx_q;
    assign tx_io.tx_v_o    = v_q;
    assign tx_io.tx_done_o = done_q;

    // tx_q is loaded with the value of the bit being entered, so the line
    // changes on the same edge as the state and no output lags by a cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (accept) begin
                    shift_q <= tx_io.tx_i;
                    par_q   <= (^tx_io.tx_i) ^ ParOdd;
                    state_q <= S_START;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    tx_q    <= 1'b0;
                    v_q     <= 1'b1;
                end
            end else begin
                // Pulse lands in the final cycle of the last stop bit.
                if (state_q == S_STOP && idx_q == StopLast && cnt_q == CntPen)
                    done_q <= 1'b1;
                if (cnt_q != CntLast) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    cnt_q <= '0;
                    case (state_q)
                        S_START: begin
                            state_q <= S_DATA;
                            idx_q   <= '0;
                            tx_q    <= shift_q[0];
                        end
                        S_DATA: begin
                            shift_q <= shift_q >> 1;
                            if (idx_q == DataLast) begin
                                idx_q <= '0;
                                if (HasPar) begin
                                    state_q <= S_PARITY;
                                    tx_q    <= par_q;
                                end else begin
                                    state_q <= S_STOP;
                                    tx_q    <= 1'b1;
                                end
                            end else begin
                                idx_q <= idx_q + 1'b1;
                                tx_q  <= shift_q[1];
                            end
                        end
                        S_PARITY: begin
                            state_q <= S_STOP;
                            idx_q   <= '0;
                            tx_q    <= 1'b1;
                        end
                        S_STOP: begin
                            if (idx_q == StopLast) begin
                                state_q <= S_IDLE;
                                idx_q   <= '0;
                                v_q     <= 1'b0;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                        default: begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                            v_q     <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_serializer.sv
// Bench for uart_serializer: four configurations (8N1, 8E1, 8O1 at 4 clk/bit; 5N2 at 3 clk/bit)
// compared cycle by cycle against a frame model built from the bit layout.
module tb_uart_serializer;

    localparam int CPB [4] = '{4, 4, 4, 3};
    localparam int DB  [4] = '{8, 8, 8, 5};
    localparam int PB  [4] = '{0, 1, 1, 0};
    localparam int PO  [4] = '{0, 0, 1, 0};
    localparam int SB  [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v [4];
    logic [8:0] d [4];
    logic       o_tx [4], o_v [4], o_done [4], o_rdy [4];
    logic [3:0] q_obs [64];   // {tx, tx_v, done, ready} per captured cycle
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    uart_serializer_if #(.DATA_BITS(8)) if0 ();
    uart_serializer_if #(.DATA_BITS(8)) if1 ();
    uart_serializer_if #(.DATA_BITS(8)) if2 ();
    uart_serializer_if #(.DATA_BITS(5)) if3 ();

    assign if0.tx_v_i = v[0];  assign if0.tx_i = d[0][7:0];
    assign if1.tx_v_i = v[1];  assign if1.tx_i = d[1][7:0];
    assign if2.tx_v_i = v[2];  assign if2.tx_i = d[2][7:0];
    assign if3.tx_v_i = v[3];  assign if3.tx_i = d[3][4:0];

    assign o_tx[0] = if0.tx_o;  assign o_v[0] = if0.tx_v_o;  assign o_done[0] = if0.tx_done_o;  assign o_rdy[0] = if0.tx_ready_and_o;
    assign o_tx[1] = if1.tx_o;  assign o_v[1] = if1.tx_v_o;  assign o_done[1] = if1.tx_done_o;  assign o_rdy[1] = if1.tx_ready_and_o;
    assign o_tx[2] = if2.tx_o;  assign o_v[2] = if2.tx_v_o;  assign o_done[2] = if2.tx_done_o;  assign o_rdy[2] = if2.tx_ready_and_o;
    assign o_tx[3] = if3.tx_o;  assign o_v[3] = if3.tx_v_o;  assign o_done[3] = if3.tx_done_o;  assign o_rdy[3] = if3.tx_ready_and_o;

    uart_serializer #(.clk_per_bit_p(4), .data_bits_p(8), .parity_bits_p(0), .parity_odd_p(0), .stop_bits_p(1))
        u_8n1 (.clk_i(clk), .reset_n_i(rst_n), .tx_io(if0));
    uart_serializer #(.clk_per_bit_p(4), .data_bits_p(8), .parity_bits_p(1), .parity_odd_p(0), .stop_bits_p(1))
        u_8e1 (.clk_i(clk), .reset_n_i(rst_n), .tx_io(if1));
    uart_serializer #(.clk_per_bit_p(4), .data_bits_p(8), .parity_bits_p(1), .parity_odd_p(1), .stop_bits_p(1))
        u_8o1 (.clk_i(clk), .reset_n_i(rst_n), .tx_io(if2));
    uart_serializer #(.clk_per_bit_p(3), .data_bits_p(5), .parity_bits_p(0), .parity_odd_p(0), .stop_bits_p(2))
        u_5n2 (.clk_i(clk), .reset_n_i(rst_n), .tx_io(if3));

    function automatic int flen(input int u);
        return CPB[u] * (1 + DB[u] + PB[u] + SB[u]);
    endfunction

    // Expected {tx, tx_v, done, ready} for cycle c (1 = first cycle after the accept edge).
    function automatic logic [3:0] exp_sig(input int u, input logic [8:0] w, input int c);
        int   f, b, ones;
        logic t;
        f    = flen(u);
        b    = (c - 1) / CPB[u];
        ones = 0;
        for (int i = 0; i < DB[u]; i++) ones += int'(w[i]);
        if (c > f)                             t = 1'b1;
        else if (b == 0)                       t = 1'b0;
        else if (b <= DB[u])                   t = w[b-1];
        else if (PB[u] == 1 && b == DB[u] + 1) t = (((ones + PO[u]) % 2) == 1);
        else                                   t = 1'b1;
        return {t, c <= f, c == f, c == f + 1};
    endfunction

    task automatic send(input int u, input logic [8:0] w, input bit keep);
        int n = 0;
        @(negedge clk);
        while (o_rdy[u] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_rdy[u] !== 1'b1) begin
            failures++;
            $display("FAIL send_ready unit%0d: ready=%b want 1", u, o_rdy[u]);
        end
        v[u] = 1'b1;
        d[u] = w;
        @(posedge clk); #1;
        if (!keep) v[u] = 1'b0;
    endtask

    // Samples n cycles starting now (first sample is the current cycle).
    task automatic capture(input int u, input int n, input bit scramble);
        for (int c = 1; c <= n; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            q_obs[c] = {o_tx[u], o_v[u], o_done[u], o_rdy[u]};
            if (scramble) d[u] = 9'($urandom);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int u = 0; u < 4; u++) begin
            checks++;
            if ({o_tx[u], o_v[u], o_done[u], o_rdy[u]} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_state unit%0d: got %b want 1000", u, {o_tx[u], o_v[u], o_done[u], o_rdy[u]});
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        for (int u = 0; u < 4; u++) begin
            checks++;
            if ({o_tx[u], o_v[u], o_done[u], o_rdy[u]} !== 4'b1001) begin
                failures++;
                $display("FAIL reset_release unit%0d: got %b want 1001", u, {o_tx[u], o_v[u], o_done[u], o_rdy[u]});
            end
        end
    endtask

    task automatic test_8n1_a5();
        int f = flen(0);
        send(0, 9'h0A5, 1'b0);
        capture(0, f + 1, 1'b0);
        for (int c = 1; c <= f + 1; c++) begin
            checks++;
            if (q_obs[c] !== exp_sig(0, 9'h0A5, c)) begin
                failures++;
                $display("FAIL frame_8n1_a5 cycle %0d: got %b want %b", c, q_obs[c], exp_sig(0, 9'h0A5, c));
            end
        end
    endtask

    task automatic test_parity();
        int         us [3] = '{1, 2, 1};
        logic [8:0] ws [3] = '{9'h007, 9'h007, 9'h000};
        logic       pb [3] = '{1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            int f = flen(us[k]);
            send(us[k], ws[k], 1'b0);
            capture(us[k], f + 1, 1'b0);
            for (int c = 1; c <= f + 1; c++) begin
                checks++;
                if (q_obs[c] !== exp_sig(us[k], ws[k], c)) begin
                    failures++;
                    $display("FAIL parity_frame%0d cycle %0d: got %b want %b", k, c, q_obs[c], exp_sig(us[k], ws[k], c));
                end
            end
            checks++;   // parity bit occupies cycles 37..40
            if (q_obs[38][3] !== pb[k]) begin
                failures++;
                $display("FAIL parity_bit%0d: got %b want %b", k, q_obs[38][3], pb[k]);
            end
        end
    endtask

    task automatic test_5n2();
        int f = flen(3);
        send(3, 9'h01F, 1'b0);
        capture(3, f + 1, 1'b0);
        for (int c = 1; c <= f + 1; c++) begin
            checks++;
            if (q_obs[c] !== exp_sig(3, 9'h01F, c)) begin
                failures++;
                $display("FAIL frame_5n2 cycle %0d: got %b want %b", c, q_obs[c], exp_sig(3, 9'h01F, c));
            end
        end
    endtask

    task automatic test_back_to_back();
        int f     = flen(0);
        int dones = 0;
        send(0, 9'h000, 1'b1);
        d[0] = 9'h0FF;
        capture(0, f + 1, 1'b0);
        for (int c = 1; c <= f + 1; c++) begin
            checks++;
            if (q_obs[c] !== exp_sig(0, 9'h000, c)) begin
                failures++;
                $display("FAIL b2b_first cycle %0d: got %b want %b", c, q_obs[c], exp_sig(0, 9'h000, c));
            end
            dones += int'(q_obs[c][1]);
        end
        @(posedge clk); #1;
        v[0] = 1'b0;
        capture(0, f + 1, 1'b0);
        for (int c = 1; c <= f + 1; c++) begin
            checks++;
            if (q_obs[c] !== exp_sig(0, 9'h0FF, c)) begin
                failures++;
                $display("FAIL b2b_second cycle %0d: got %b want %b", c, q_obs[c], exp_sig(0, 9'h0FF, c));
            end
            dones += int'(q_obs[c][1]);
        end
        checks++;
        if (dones != 2) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d want 2", dones);
        end
    endtask

    task automatic test_mid_change();
        int         f = flen(2);
        logic [8:0] w = 9'($urandom_range(0, 255));
        send(2, w, 1'b1);
        capture(2, f + 1, 1'b1);
        v[2] = 1'b0;
        for (int c = 1; c <= f + 1; c++) begin
            checks++;
            if (q_obs[c] !== exp_sig(2, w, c)) begin
                failures++;
                $display("FAIL mid_change cycle %0d: got %b want %b", c, q_obs[c], exp_sig(2, w, c));
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({o_tx[2], o_v[2], o_done[2], o_rdy[2]} !== 4'b1001) begin
            failures++;
            $display("FAIL mid_change_idle: got %b want 1001", {o_tx[2], o_v[2], o_done[2], o_rdy[2]});
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            int         u = $urandom_range(0, 3);
            int         f = flen(u);
            logic [8:0] w = 9'($urandom);
            send(u, w, 1'b0);
            capture(u, f + 1, 1'b0);
            for (int c = 1; c <= f + 1; c++) begin
                checks++;
                if (q_obs[c] !== exp_sig(u, w, c)) begin
                    failures++;
                    $display("FAIL random%0d unit%0d cycle %0d: got %b want %b", k, u, c, q_obs[c], exp_sig(u, w, c));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int f   = flen(0);
        int bad = 0;
        send(0, 9'h0A5, 1'b0);
        repeat (17) @(posedge clk);
        #1;   // cycle 18: data bit 3 of 0xA5, which is 0
        checks++;
        if (o_tx[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_pre: tx=%b want 0", o_tx[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_tx[0], o_v[0], o_done[0], o_rdy[0]} !== 4'b1000) begin
            failures++;
            $display("FAIL rst_mid_async: got %b want 1000", {o_tx[0], o_v[0], o_done[0], o_rdy[0]});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < f; c++) begin
            @(posedge clk); #1;
            if (o_done[0] !== 1'b0 || o_tx[0] !== 1'b1 || o_v[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_mid_quiet: %0d busy/done cycles want 0", bad);
        end
        send(0, 9'h03C, 1'b0);
        capture(0, f + 1, 1'b0);
        for (int c = 1; c <= f + 1; c++) begin
            checks++;
            if (q_obs[c] !== exp_sig(0, 9'h03C, c)) begin
                failures++;
                $display("FAIL rst_mid_3c cycle %0d: got %b want %b", c, q_obs[c], exp_sig(0, 9'h03C, c));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 4; u++) begin
            v[u] = 1'b0;
            d[u] = '0;
        end
        test_reset();
        test_8n1_a5();
        test_parity();
        test_5n2();
        test_back_to_back();
        test_mid_change();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
